bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 18 +
 rtl/addr_shift.sv | 42 ++++
 rtl/bus_arbiter.sv | 169 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and default parameters for the two-master bus arbiter.
// Contents:
//   arb_state_t      - arbiter FSM state encoding
//   SLAVE_LEN_DEF    - default width of the serial slave ID
//   ADDR_TIMEOUT_DEF - default number of ADDR cycles before the request is aborted
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_CHECK   = 2'd2,
    ST_CONNECT = 2'd3
  } arb_state_t;

  localparam int SLAVE_LEN_DEF    = 2;
  localparam int ADDR_TIMEOUT_DEF = 16;

endpackage

// File: rtl/addr_shift.sv
// Serial-to-parallel shifter for the slave ID, MSB first.
// Ports:
//   clock, rst       - system clock, asynchronous active-low reset
//   clear            - synchronous clear of the ID and bit count
//   shift_en         - the current bit_in is valid and is taken on this edge
//   bit_in           - serial ID bit
//   id               - assembled ID
//   done             - combinational: the bit taken on this edge completes the ID
module addr_shift
  import bus_pkg::*;
#(
  parameter int LEN = SLAVE_LEN_DEF
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           clear,
  input  logic           shift_en,
  input  logic           bit_in,
  output logic [LEN-1:0] id,
  output logic           done
);

  localparam int CW = $clog2(LEN + 1);

  logic [CW-1:0] count;

  assign done = shift_en && (count == CW'(LEN - 1));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      id    <= '0;
      count <= '0;
    end else if (clear) begin
      id    <= '0;
      count <= '0;
    end else if (shift_en) begin
      id    <= (id << 1) | LEN'(bit_in);
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with serial slave addressing.
// A master requests the bus, is granted, shifts in a slave ID, and is connected
// to that slave if it is ready; otherwise the request is refused with nack.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on simultaneous
// requests; without it master1 has fixed priority).
// Ports:
//   clock, rst                  - system clock, asynchronous active-low reset
//   m1_req, m2_req              - bus requests
//   m1_addr_bit, m2_addr_bit    - serial slave ID bits, MSB first
//   m1_addr_valid, m2_addr_valid- qualifiers for the ID bits
//   slave_ready                 - per-slave ready flags
//   trans_done                  - end-of-transaction pulse from the selected slave
//   m1_grant, m2_grant          - bus ownership
//   m_sel                       - master mux select (0 = master1, 1 = master2)
//   slave_sel                   - one-hot slave select while connected
//   ack, nack                   - one-cycle connect / refuse pulses
//   bus_busy                    - arbiter not idle
//
// state   | meaning
// IDLE    | no owner; arbitrate pending requests
// ADDR    | owner granted, collecting the serial slave ID, timeout running
// CHECK   | one cycle: test slave_ready for the collected ID
// CONNECT | owner connected to slave until trans_done or req drop
module bus_arbiter
  import bus_pkg::*;
#(
  parameter  int SLAVE_LEN    = SLAVE_LEN_DEF,
  parameter  int ADDR_TIMEOUT = ADDR_TIMEOUT_DEF,
  localparam int NUM_SLAVES   = 2 ** SLAVE_LEN
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  m1_req,
  input  logic                  m2_req,
  input  logic                  m1_addr_bit,
  input  logic                  m2_addr_bit,
  input  logic                  m1_addr_valid,
  input  logic                  m2_addr_valid,
  input  logic [NUM_SLAVES-1:0] slave_ready,
  input  logic                  trans_done,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic                  m_sel,
  output logic [NUM_SLAVES-1:0] slave_sel,
  output logic                  ack,
  output logic                  nack,
  output logic                  bus_busy
);

  localparam int TW = $clog2(ADDR_TIMEOUT + 1);

  arb_state_t           state, next_state;
  logic                 owner, next_owner;   // 0 = master1, 1 = master2
  logic                 pick;
  logic [TW-1:0]        tmo_cnt;
  logic                 ack_d, nack_d;
  logic                 owner_req, owner_valid, owner_bit;
  logic                 shift_en, shift_clear, id_done;
  logic [SLAVE_LEN-1:0] id;

  assign owner_req   = owner ? m2_req        : m1_req;
  assign owner_valid = owner ? m2_addr_valid : m1_addr_valid;
  assign owner_bit   = owner ? m2_addr_bit   : m1_addr_bit;

  // Clearing in IDLE guarantees a fresh bit count on every entry to ADDR
  // while keeping the ID stable through CHECK and CONNECT.
  assign shift_en    = (state == ST_ADDR) && owner_valid;
  assign shift_clear = (state == ST_IDLE);

  addr_shift #(
    .LEN(SLAVE_LEN)
  ) u_addr_shift (
    .clock   (clock),
    .rst     (rst),
    .clear   (shift_clear),
    .shift_en(shift_en),
    .bit_in  (owner_bit),
    .id      (id),
    .done    (id_done)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  assign pick = (m1_req && m2_req) ? ~last_owner : ~m1_req;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      last_owner <= 1'b1;
    end else if ((state == ST_IDLE) && (m1_req || m2_req)) begin
      last_owner <= pick;
    end
  end
`else
  assign pick = ~m1_req;
`endif

  always_comb begin
    next_state = state;
    next_owner = owner;
    ack_d      = 1'b0;
    nack_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (m1_req || m2_req) begin
          next_state = ST_ADDR;
          next_owner = pick;
        end
      end
      ST_ADDR: begin
        // A completing ID wins over a timeout on the same cycle.
        if (!owner_req) begin
          next_state = ST_IDLE;
        end else if (id_done) begin
          next_state = ST_CHECK;
        end else if (tmo_cnt == '0) begin
          next_state = ST_IDLE;
          nack_d     = 1'b1;
        end
      end
      ST_CHECK: begin
        if (!owner_req) begin
          next_state = ST_IDLE;
        end else if (slave_ready[id]) begin
          next_state = ST_CONNECT;
          ack_d      = 1'b1;
        end else begin
          next_state = ST_IDLE;
          nack_d     = 1'b1;
        end
      end
      ST_CONNECT: begin
        if (!owner_req || trans_done) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Timeout is a down-counter reloaded in IDLE; terminal count 0 marks the
  // last permitted ADDR cycle.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      tmo_cnt <= '0;
      ack     <= 1'b0;
      nack    <= 1'b0;
    end else begin
      state <= next_state;
      owner <= next_owner;
      ack   <= ack_d;
      nack  <= nack_d;
      if (state == ST_IDLE) begin
        tmo_cnt <= TW'(ADDR_TIMEOUT - 1);
      end else if ((state == ST_ADDR) && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - TW'(1);
      end
    end
  end

  assign bus_busy  = (state != ST_IDLE);
  assign m1_grant  = bus_busy && !owner;
  assign m2_grant  = bus_busy && owner;
  assign m_sel     = bus_busy && owner;
  assign slave_sel = (state == ST_CONNECT) ? (NUM_SLAVES'(1) << id) : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int SL = 2;
  localparam int NS = 4;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          rst = 1'b0;
  logic          m1_req = 1'b0, m2_req = 1'b0;
  logic          m1_addr_bit = 1'b0, m2_addr_bit = 1'b0;
  logic          m1_addr_valid = 1'b0, m2_addr_valid = 1'b0;
  logic [NS-1:0] slave_ready = '0;
  logic          trans_done = 1'b0;
  logic          m1_grant, m2_grant, m_sel, ack, nack, bus_busy;
  logic [NS-1:0] slave_sel;

  int checks = 0;
  int errors = 0;

  bus_arbiter dut (
    .clock        (clock),
    .rst          (rst),
    .m1_req       (m1_req),
    .m2_req       (m2_req),
    .m1_addr_bit  (m1_addr_bit),
    .m2_addr_bit  (m2_addr_bit),
    .m1_addr_valid(m1_addr_valid),
    .m2_addr_valid(m2_addr_valid),
    .slave_ready  (slave_ready),
    .trans_done   (trans_done),
    .m1_grant     (m1_grant),
    .m2_grant     (m2_grant),
    .m_sel        (m_sel),
    .slave_sel    (slave_sel),
    .ack          (ack),
    .nack         (nack),
    .bus_busy     (bus_busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 collecting ID, 2 checking, 3 connected.
  int m_phase = 0, m_owner = 0, m_last = 2;
  int m_id = 0, m_nbits = 0, m_acyc = 0;
  bit m_ack = 0, m_nack = 0;

  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      m_phase = 0; m_owner = 0; m_last = 2;
      m_id = 0; m_nbits = 0; m_acyc = 0;
      m_ack = 0; m_nack = 0;
    end else begin
      bit r, v, b;
      r = (m_owner == 1) ? m1_req : m2_req;
      v = (m_owner == 1) ? m1_addr_valid : m2_addr_valid;
      b = (m_owner == 1) ? m1_addr_bit : m2_addr_bit;
      m_ack = 0;
      m_nack = 0;
      case (m_phase)
        0: if (m1_req || m2_req) begin
`ifdef ARB_ROUND_ROBIN_EN
             if (m1_req && m2_req) m_owner = (m_last == 1) ? 2 : 1;
             else m_owner = m1_req ? 1 : 2;
             m_last = m_owner;
`else
             m_owner = m1_req ? 1 : 2;
`endif
             m_phase = 1; m_id = 0; m_nbits = 0; m_acyc = 0;
           end
        1: if (!r) m_phase = 0;
           else begin
             if (v) begin m_id = m_id * 2 + int'(b); m_nbits++; end
             m_acyc++;
             if (m_nbits == SL) m_phase = 2;
             else if (m_acyc == TO) begin m_phase = 0; m_nack = 1; end
           end
        2: if (!r) m_phase = 0;
           else if (slave_ready[m_id]) begin m_phase = 3; m_ack = 1; end
           else begin m_phase = 0; m_nack = 1; end
        3: if (!r || trans_done) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    logic [NS-1:0] e_sel;
    e_sel = (m_phase == 3) ? NS'(1 << m_id) : '0;
    chk("m1_grant", 32'(m1_grant), 32'(m_phase != 0 && m_owner == 1));
    chk("m2_grant", 32'(m2_grant), 32'(m_phase != 0 && m_owner == 2));
    chk("m_sel", 32'(m_sel), 32'(m_phase != 0 && m_owner == 2));
    chk("bus_busy", 32'(bus_busy), 32'(m_phase != 0));
    chk("slave_sel", 32'(slave_sel), 32'(e_sel));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("nack", 32'(nack), 32'(m_nack));
    chk("ack_nack_excl", 32'(ack && nack), 32'd0);
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_inputs();
    m1_req = 0; m2_req = 0;
    m1_addr_valid = 0; m2_addr_valid = 0;
    m1_addr_bit = 0; m2_addr_bit = 0;
    slave_ready = '0; trans_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic set_addr(input int m, input bit v, input bit b);
    m1_addr_valid = (m == 1) && v; m1_addr_bit = (m == 1) && b;
    m2_addr_valid = (m == 2) && v; m2_addr_bit = (m == 2) && b;
  endtask

  task automatic send_id(input int m, input int idv);
    for (int i = SL - 1; i >= 0; i--) begin
      set_addr(m, 1'b1, idv[i]);
      tick();
    end
    set_addr(m, 1'b0, 1'b0);
  endtask

  initial begin
    int vprob;

    // reset state
    tick();
    chk("rst_busy", 32'(bus_busy), 32'd0);
    chk("rst_grants", 32'({m1_grant, m2_grant, m_sel}), 32'd0);
    chk("rst_sel", 32'(slave_sel), 32'd0);
    rst = 1;

    // master1, ID 2'b10, slave 2 ready
    do_reset();
    m1_req = 1; slave_ready = 4'b0100;
    tick();
    chk("s1_grant", 32'({m1_grant, m2_grant, m_sel}), 32'b100);
    send_id(1, 2);
    chk("s1_no_ack_yet", 32'(ack), 32'd0);
    tick();
    chk("s1_ack", 32'(ack), 32'd1);
    chk("s1_slave_sel", 32'(slave_sel), 32'b0100);
    trans_done = 1;
    tick();
    trans_done = 0; m1_req = 0;
    chk("s1_done_busy", 32'(bus_busy), 32'd0);
    chk("s1_done_sel", 32'(slave_sel), 32'd0);
    chk("s1_ack_pulse", 32'(ack), 32'd0);

    // simultaneous requests, two back-to-back transactions
    do_reset();
    m1_req = 1; m2_req = 1; slave_ready = 4'hF;
    tick();
    chk("s2_first_owner", 32'({m1_grant, m2_grant}), 32'b10);
    send_id(1, 1);
    tick();
    trans_done = 1;
    tick();
    trans_done = 0;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    chk("s2_second_owner", 32'({m1_grant, m2_grant}), 32'b01);
`else
    chk("s2_second_owner", 32'({m1_grant, m2_grant}), 32'b10);
`endif
    m1_req = 0; m2_req = 0;
    tick();
    tick();

    // slave 3 not ready -> nack, pending master2 served next
    do_reset();
    m1_req = 1; m2_req = 1; slave_ready = 4'b0111;
    tick();
    send_id(1, 3);
    tick();
    chk("s3_nack", 32'(nack), 32'd1);
    chk("s3_grant_drop", 32'({m1_grant, m2_grant}), 32'd0);
    m1_req = 0;
    tick();
    chk("s3_m2_grant", 32'({m2_grant, m_sel}), 32'b11);
    chk("s3_nack_pulse", 32'(nack), 32'd0);
    m2_req = 0;
    tick();

    // master2 stalls after one bit -> timeout
    do_reset();
    m2_req = 1;
    tick();
    set_addr(2, 1'b1, 1'b1);
    tick();
    set_addr(2, 1'b0, 1'b0);
    repeat (TO - 2) tick();
    chk("s4_still_granted", 32'(m2_grant), 32'd1);
    chk("s4_no_early_nack", 32'(nack), 32'd0);
    tick();
    chk("s4_nack", 32'(nack), 32'd1);
    chk("s4_grant_drop", 32'(m2_grant), 32'd0);
    m2_req = 0;
    tick();

    // async reset during CONNECT
    do_reset();
    m1_req = 1; slave_ready = 4'b0100;
    tick();
    send_id(1, 2);
    tick();
    chk("s5_connected", 32'(slave_sel), 32'b0100);
    #1 rst = 0;
    #1;
    chk("s5_sel_cleared", 32'(slave_sel), 32'd0);
    chk("s5_grant_cleared", 32'({m1_grant, m2_grant}), 32'd0);
    chk("s5_no_ack_nack", 32'({ack, nack}), 32'd0);
    tick();
    m1_req = 0;
    rst = 1;
    tick();

    // master1 drops req in CONNECT; later trans_done ignored
    do_reset();
    m1_req = 1; slave_ready = 4'b0001;
    tick();
    send_id(1, 0);
    tick();
    m1_req = 0;
    tick();
    chk("s6_idle", 32'(bus_busy), 32'd0);
    trans_done = 1;
    tick();
    trans_done = 0;
    chk("s6_late_done", 32'({bus_busy, ack, nack, slave_sel}), 32'd0);
    tick();

    // randomized traffic against the model
    do_reset();
    vprob = 60;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) vprob = (vprob == 60) ? 6 : 60;
      if ($urandom_range(0, 99) < 10) m1_req = ~m1_req;
      if ($urandom_range(0, 99) < 10) m2_req = ~m2_req;
      m1_addr_valid = ($urandom_range(0, 99) < vprob);
      m2_addr_valid = ($urandom_range(0, 99) < vprob);
      m1_addr_bit = 1'($urandom_range(0, 1));
      m2_addr_bit = 1'($urandom_range(0, 1));
      slave_ready = NS'($urandom());
      trans_done = ($urandom_range(0, 99) < 15);
      rst = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst = 1;
    clear_inputs();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
